i2c_bus_monitor: RTL and testbench

I2C_BUS_MONITOR -- requirements
Module: i2c_bus_monitor

---
 rtl/i2c_bus_monitor.sv | 196 +++++++++++++++++++
 tb/tb_i2c_bus_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: passive I2C line observer.
// - Synchronizes and deglitches SCL/SDA.
// - Reports edge pulses and START / repeated START / STOP pulses.
// - Tracks bus_busy, plus bus_free after an idle qualification period.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int IDLE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  input  logic sample_en,
  output logic scl_filt,
  output logic sda_filt,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_rise,
  output logic sda_fall,
  output logic start_det,
  output logic rstart_det,
  output logic stop_det,
  output logic bus_busy,
  output logic bus_free
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(FILTER_LEN - 1);
  localparam logic [IW-1:0] I_MAX  = IW'(IDLE_CYCLES);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic [CW-1:0]          r_scl_cnt;
  logic [CW-1:0]          r_sda_cnt;
  logic                   r_scl_filt;
  logic                   r_sda_filt;
  logic [IW-1:0]          r_idle;
  logic                   r_bus_busy;
  logic                   r_bus_free;
  logic                   r_scl_rise;
  logic                   r_scl_fall;
  logic                   r_sda_rise;
  logic                   r_sda_fall;
  logic                   r_start;
  logic                   r_rstart;
  logic                   r_stop;

  logic          w_scl_sync;
  logic          w_sda_sync;
  logic          w_scl_mis;
  logic          w_sda_mis;
  logic          w_scl_tog;
  logic          w_sda_tog;
  logic          w_scl_rise_nxt;
  logic          w_scl_fall_nxt;
  logic          w_sda_rise_nxt;
  logic          w_sda_fall_nxt;
  logic          w_start_nxt;
  logic          w_rstart_nxt;
  logic          w_stop_nxt;
  logic          w_busy_nxt;
  logic [IW-1:0] w_idle_nxt;

  // Synchronizers run free on every clock; they reset to the idle-high level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign w_scl_sync = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_sync = r_sda_sync[SYNC_STAGES-1];

  // The filtered level toggles on the FILTER_LEN-th consecutive mismatch.
  assign w_scl_mis = (w_scl_sync != r_scl_filt);
  assign w_sda_mis = (w_sda_sync != r_sda_filt);
  assign w_scl_tog = sample_en & w_scl_mis & (r_scl_cnt == C_LAST);
  assign w_sda_tog = sample_en & w_sda_mis & (r_sda_cnt == C_LAST);

  // The toggle direction follows from the current filtered level.
  assign w_scl_rise_nxt = w_scl_tog & ~r_scl_filt;
  assign w_scl_fall_nxt = w_scl_tog & r_scl_filt;
  assign w_sda_rise_nxt = w_sda_tog & ~r_sda_filt;
  assign w_sda_fall_nxt = w_sda_tog & r_sda_filt;

  // START/STOP need SCL high and stable in the same update.
  assign w_start_nxt  = w_sda_fall_nxt & r_scl_filt & ~w_scl_tog;
  assign w_stop_nxt   = w_sda_rise_nxt & r_scl_filt & ~w_scl_tog;
  assign w_rstart_nxt = w_start_nxt & r_bus_busy;

  // SCL deglitch counter and filtered level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_filt <= 1'b1;
      r_scl_cnt  <= CW'(0);
    end else if (sample_en) begin
      if (!w_scl_mis) begin
        r_scl_cnt <= CW'(0);
      end else if (r_scl_cnt == C_LAST) begin
        r_scl_filt <= ~r_scl_filt;
        r_scl_cnt  <= CW'(0);
      end else begin
        r_scl_cnt <= r_scl_cnt + CW'(1);
      end
    end else begin
      r_scl_cnt <= r_scl_cnt;
    end
  end

  // SDA deglitch counter and filtered level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sda_filt <= 1'b1;
      r_sda_cnt  <= CW'(0);
    end else if (sample_en) begin
      if (!w_sda_mis) begin
        r_sda_cnt <= CW'(0);
      end else if (r_sda_cnt == C_LAST) begin
        r_sda_filt <= ~r_sda_filt;
        r_sda_cnt  <= CW'(0);
      end else begin
        r_sda_cnt <= r_sda_cnt + CW'(1);
      end
    end else begin
      r_sda_cnt <= r_sda_cnt;
    end
  end

  // Bus ownership: set by START, cleared by STOP, otherwise held.
  always_comb begin
    if (w_start_nxt) begin
      w_busy_nxt = 1'b1;
    end else if (w_stop_nxt) begin
      w_busy_nxt = 1'b0;
    end else begin
      w_busy_nxt = r_bus_busy;
    end
  end

  // Idle qualification: count enabled samples with both lines high, saturating.
  always_comb begin
    if (w_scl_fall_nxt | w_sda_fall_nxt | r_bus_busy) begin
      w_idle_nxt = IW'(0);
    end else if (sample_en & r_scl_filt & r_sda_filt & (r_idle != I_MAX)) begin
      w_idle_nxt = r_idle + IW'(1);
    end else begin
      w_idle_nxt = r_idle;
    end
  end

  // Registered pulses, bus state and idle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_sda_rise <= 1'b0;
      r_sda_fall <= 1'b0;
      r_start    <= 1'b0;
      r_rstart   <= 1'b0;
      r_stop     <= 1'b0;
      r_bus_busy <= 1'b0;
      r_idle     <= IW'(0);
      r_bus_free <= 1'b0;
    end else begin
      r_scl_rise <= w_scl_rise_nxt;
      r_scl_fall <= w_scl_fall_nxt;
      r_sda_rise <= w_sda_rise_nxt;
      r_sda_fall <= w_sda_fall_nxt;
      r_start    <= w_start_nxt;
      r_rstart   <= w_rstart_nxt;
      r_stop     <= w_stop_nxt;
      r_bus_busy <= w_busy_nxt;
      r_idle     <= w_idle_nxt;
      r_bus_free <= ~w_busy_nxt & (w_idle_nxt == I_MAX);
    end
  end

  assign scl_filt   = r_scl_filt;
  assign sda_filt   = r_sda_filt;
  assign scl_rise   = r_scl_rise;
  assign scl_fall   = r_scl_fall;
  assign sda_rise   = r_sda_rise;
  assign sda_fall   = r_sda_fall;
  assign start_det  = r_start;
  assign rstart_det = r_rstart;
  assign stop_det   = r_stop;
  assign bus_busy   = r_bus_busy;
  assign bus_free   = r_bus_free;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Scoreboard bench for i2c_bus_monitor.
// - Stimulus pushes the expected pulse pattern and arrival cycle onto a queue.
// - The monitor pops and compares whenever any pulse output is high.
module tb_i2c_bus_monitor;

  localparam int LAT = 5;  // SYNC_STAGES + FILTER_LEN with sample_en held high

  localparam logic [6:0] EV_SCLR = 7'b1000000;
  localparam logic [6:0] EV_SCLF = 7'b0100000;
  localparam logic [6:0] EV_SDAR = 7'b0010000;
  localparam logic [6:0] EV_SDAF = 7'b0001000;
  localparam logic [6:0] EV_STA  = 7'b0000100;
  localparam logic [6:0] EV_RSTA = 7'b0000010;
  localparam logic [6:0] EV_STO  = 7'b0000001;

  typedef struct {
    int         cyc;
    logic [6:0] ev;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset, scl_in, sda_in, sample_en;
  logic scl_filt, sda_filt, scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, rstart_det, stop_det, bus_busy, bus_free;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;
  logic en_q = 1'b0;

  i2c_bus_monitor #(.SYNC_STAGES(2), .FILTER_LEN(3), .IDLE_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
    .sample_en(sample_en), .scl_filt(scl_filt), .sda_filt(sda_filt),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .sda_rise(sda_rise),
    .sda_fall(sda_fall), .start_det(start_det), .rstart_det(rstart_det),
    .stop_det(stop_det), .bus_busy(bus_busy), .bus_free(bus_free)
  );

  always #5 clk = ~clk;

  // Edge counter and the sample_en value each edge saw.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    en_q <= sample_en;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int at, input logic [6:0] ev, input logic busy);
    exp_t e;
    e.cyc = at; e.ev = ev; e.busy = busy;
    exp_q.push_back(e);
  endtask

  // Change the pins, expect ev (if any) LAT edges later, then let it settle.
  task automatic drive(input logic scl, input logic sda, input logic [6:0] ev, input logic busy);
    scl_in = scl;
    sda_in = sda;
    if (ev != 7'b0) push(cyc + LAT, ev, busy);
    step(8);
  endtask

  // Monitor: compare every observed pulse pattern against the scoreboard.
  always @(negedge clk) begin
    logic [6:0] got;
    exp_t e;
    if (mon_en) begin
      got = {scl_rise, scl_fall, sda_rise, sda_fall, start_det, rstart_det, stop_det};
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_event: expected ev=%b at cyc %0d, nothing seen", e.ev, e.cyc);
      end
      if (got != 7'b0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: got ev=%b busy=%b at cyc %0d, expected none", got, bus_busy, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.ev != got || e.busy != bus_busy) begin
            miscompares++;
            $display("FAIL event: got ev=%b busy=%b cyc=%0d expected ev=%b busy=%b cyc=%0d",
                     got, bus_busy, cyc, e.ev, e.busy, e.cyc);
          end
        end
        vectors++;
        if (en_q != 1'b1) begin
          miscompares++;
          $display("FAIL pulse_on_en0: got pulse ev=%b on sample_en=0 edge, expected none", got);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_cyc;
    int c0;
    reset = 1'b1; scl_in = 1'b1; sda_in = 1'b1; sample_en = 1'b1;
    step(3);
    chk("rst_scl_filt", int'(scl_filt), 1);
    chk("rst_sda_filt", int'(sda_filt), 1);
    chk("rst_busy", int'(bus_busy), 0);
    chk("rst_free", int'(bus_free), 0);
    chk("rst_pulses", int'({scl_rise, scl_fall, sda_rise, sda_fall, start_det, rstart_det, stop_det}), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // bus_free after exactly 16 enabled idle samples
    step(15);
    chk("free_at_15", int'(bus_free), 0);
    step(1);
    chk("free_at_16", int'(bus_free), 1);

    // 2-cycle low glitch on SDA: filtered away, no pulses
    sda_in = 1'b0;
    step(2);
    sda_in = 1'b1;
    step(8);
    chk("glitch_sda_filt", int'(sda_filt), 1);
    chk("glitch_free", int'(bus_free), 1);

    // START from idle, then 9 SCL clocks
    drive(1'b1, 1'b0, EV_SDAF | EV_STA, 1'b1);
    chk("start_free", int'(bus_free), 0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b0, EV_SCLF, 1'b1);
      drive(1'b1, 1'b0, EV_SCLR, 1'b1);
    end

    // repeated START
    drive(1'b0, 1'b0, EV_SCLF, 1'b1);
    drive(1'b0, 1'b1, EV_SDAR, 1'b1);
    drive(1'b1, 1'b1, EV_SCLR, 1'b1);
    drive(1'b1, 1'b0, EV_SDAF | EV_STA | EV_RSTA, 1'b1);
    chk("rstart_busy", int'(bus_busy), 1);

    // STOP, then free after 16 further idle samples
    sda_in = 1'b1;
    e_cyc = cyc + LAT;
    push(e_cyc, EV_SDAR | EV_STO, 1'b0);
    step(LAT);
    chk("stop_busy", int'(bus_busy), 0);
    step(15);
    chk("stop_free_15", int'(bus_free), 0);
    step(1);
    chk("stop_free_16", int'(bus_free), 1);

    // STOP followed quickly by START: plain START, no rstart
    drive(1'b1, 1'b0, EV_SDAF | EV_STA, 1'b1);
    drive(1'b1, 1'b1, EV_SDAR | EV_STO, 1'b0);
    drive(1'b1, 1'b0, EV_SDAF | EV_STA, 1'b1);
    drive(1'b1, 1'b1, EV_SDAR | EV_STO, 1'b0);
    chk("quick_restart_free", int'(bus_free), 0);

    // SCL and SDA changing together: edges only, no START/STOP
    drive(1'b0, 1'b0, EV_SCLF | EV_SDAF, 1'b0);
    drive(1'b1, 1'b1, EV_SCLR | EV_SDAR, 1'b0);
    chk("simul_busy", int'(bus_busy), 0);
    step(12);

    // sample_en alternating. The synchronizer still runs every edge:
    // sync output is new after edge c+2, enabled edges are c+2, c+4, ...,
    // so the three filter samples land on c+4, c+6, c+8.
    sample_en = 1'b0;
    sda_in = 1'b0;
    c0 = cyc;
    push(c0 + 8, EV_SDAF | EV_STA, 1'b1);
    for (int i = 0; i < 14; i++) begin
      step(1);
      sample_en = ~sample_en;
    end
    sample_en = 1'b1;
    step(4);
    chk("en_toggle_busy", int'(bus_busy), 1);

    // reset while busy, pins returned high so no START follows release
    reset = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
    step(1);
    chk("mid_rst_busy", int'(bus_busy), 0);
    chk("mid_rst_scl_filt", int'(scl_filt), 1);
    chk("mid_rst_sda_filt", int'(sda_filt), 1);
    chk("mid_rst_free", int'(bus_free), 0);
    chk("mid_rst_pulses", int'({scl_rise, scl_fall, sda_rise, sda_fall, start_det, rstart_det, stop_det}), 0);
    reset = 1'b0;
    step(15);
    chk("mid_rst_free_15", int'(bus_free), 0);
    step(1);
    chk("mid_rst_free_16", int'(bus_free), 1);

    step(10);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
